// File: rtl/frame_pkg.sv
// Shared framing constants for the serializer and the receive-side deframer.
package frame_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hAA;
  localparam logic [7:0] FTR_MAGIC = 8'h55;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    DROP    = 3'd3,
    FOOTER  = 3'd4
  } state_e;

  // Header: {magic, ch_id, frame_id, timestamp}
  localparam int HDR_MAGIC_LSB = 56;
  localparam int HDR_CH_LSB    = 48;
  localparam int HDR_FID_LSB   = 32;
  localparam int HDR_TS_LSB    = 0;

  // Footer: {magic, 7'b0, ovf, word_cnt, frame_id, 16'h0}
  localparam int FTR_MAGIC_LSB = 56;
  localparam int FTR_OVF_BIT   = 48;
  localparam int FTR_CNT_LSB   = 32;
  localparam int FTR_FID_LSB   = 16;

  function automatic logic [63:0] mk_header(input logic [7:0] ch, input logic [15:0] fid,
                                            input logic [31:0] ts);
    return {HDR_MAGIC, ch, fid, ts};
  endfunction

  function automatic logic [63:0] mk_footer(input logic ovf, input logic [15:0] cnt,
                                            input logic [15:0] fid);
    return {FTR_MAGIC, 7'd0, ovf, cnt, fid, 16'h0000};
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// Wraps each TLAST-delimited AXI-Stream packet in header/footer words and
// emits a flat registered word stream for the Ethernet TX FIFO.
module frame_serializer
  import frame_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 64,
  parameter int TX_RX_M_AXIS_WIDTH = 64,
  parameter int MAX_WORDS          = 256
) (
  input  logic                          TX_ACLK,
  input  logic                          TX_ARESET,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  input  logic                          S_AXIS_TLAST,
  output logic                          S_AXIS_TREADY,
  input  logic [7:0]                    CH_ID,
  input  logic                          PLS_WAIT,
  output logic [TX_RX_M_AXIS_WIDTH-1:0] SERIALIZED_DATA,
  output logic                          WR_EN,
  output logic                          FRAME_OVF
);

  state_e                        state_q, state_d;
  logic [7:0]                    ch_q, ch_d;
  logic [31:0]                   ts_q;
  logic [31:0]                   ts_cap_q, ts_cap_d;
  logic [15:0]                   frame_id_q, frame_id_d;
  logic [15:0]                   word_cnt_q, word_cnt_d;
  logic                          ovf_q, ovf_d;
  logic [TX_RX_M_AXIS_WIDTH-1:0] data_q, data_d;
  logic                          wr_q, wr_d;
  logic                          fovf_q, fovf_d;

  logic        tready;
  logic        hs;
  logic [16:0] cnt_inc;

  // DROP keeps draining the source even while downstream is stalled.
  always_comb begin
    tready = 1'b0;
    case (state_q)
      PAYLOAD: tready = !PLS_WAIT;
      DROP:    tready = 1'b1;
      default: tready = 1'b0;
    endcase
  end

  assign hs            = S_AXIS_TVALID && tready;
  assign cnt_inc       = {1'b0, word_cnt_q} + 17'd1;
  assign S_AXIS_TREADY = tready;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    ts_cap_d   = ts_cap_q;
    frame_id_d = frame_id_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    fovf_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (S_AXIS_TVALID) begin
          ch_d       = CH_ID;
          ts_cap_d   = ts_q;
          word_cnt_d = 16'd0;
          ovf_d      = 1'b0;
          state_d    = HEADER;
        end
      end
      HEADER: begin
        if (!PLS_WAIT) begin
          data_d  = mk_header(ch_q, frame_id_q, ts_cap_q);
          wr_d    = 1'b1;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (hs) begin
          data_d     = S_AXIS_TDATA;
          wr_d       = 1'b1;
          word_cnt_d = cnt_inc[15:0];
          if (S_AXIS_TLAST) begin
            state_d = FOOTER;
          end else if (cnt_inc == 17'(MAX_WORDS)) begin
            ovf_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (hs && S_AXIS_TLAST) state_d = FOOTER;
      end
      FOOTER: begin
        if (!PLS_WAIT) begin
          data_d     = mk_footer(ovf_q, word_cnt_q, frame_id_q);
          wr_d       = 1'b1;
          fovf_d     = ovf_q;
          frame_id_d = frame_id_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge TX_ACLK) begin
    if (TX_ARESET) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      ts_q       <= '0;
      ts_cap_q   <= '0;
      frame_id_q <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      fovf_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      ts_q       <= ts_q + 32'd1;
      ts_cap_q   <= ts_cap_d;
      frame_id_q <= frame_id_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      fovf_q     <= fovf_d;
    end
  end

  assign SERIALIZED_DATA = data_q;
  assign WR_EN           = wr_q;
  assign FRAME_OVF       = fovf_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboarded random/directed bench for frame_serializer (MAX_WORDS=4).
module tb_frame_serializer;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [7:0]  ch_id = '0;
  logic        pls = 1'b0;
  logic [63:0] sdata;
  logic        wr_en;
  logic        fovf;

  always #5 clk = ~clk;

  frame_serializer #(
    .S_AXIS_TDATA_WIDTH(64),
    .TX_RX_M_AXIS_WIDTH(64),
    .MAX_WORDS(MAXW)
  ) dut (
    .TX_ACLK(clk),
    .TX_ARESET(rst),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(tready),
    .CH_ID(ch_id),
    .PLS_WAIT(pls),
    .SERIALIZED_DATA(sdata),
    .WR_EN(wr_en),
    .FRAME_OVF(fovf)
  );

  typedef struct {
    logic [63:0] d;
    logic        ovf;
    logic        ftr;
  } exp_t;

  exp_t        expq[$];
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] ts_model;
  logic [15:0] exp_fid = 16'h0;
  int          stall_cnt = 0;
  bit          rand_pls = 0;
  bit          rand_gap = 0;
  bit          stall_chk = 0;

  // Cycle count since reset: the value a frame captures as its timestamp.
  always @(posedge clk) ts_model <= rst ? 32'd0 : ts_model + 32'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  logic prev_pls = 1'b0;
  logic prev_ftr = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (prev_pls) check("stall_no_wr", {63'd0, wr_en}, 64'd0);
    if (prev_ftr) check("idle_gap", {63'd0, wr_en}, 64'd0);
    prev_ftr = 1'b0;
    if (wr_en) begin
      if (expq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_wr: got word %h expected no write", sdata);
      end else begin
        mon_e = expq.pop_front();
        check("word", sdata, mon_e.d);
        check("frame_ovf", {63'd0, fovf}, {63'd0, mon_e.ovf});
        prev_ftr = mon_e.ftr;
      end
    end else if (fovf) begin
      check("frame_ovf_idle", {63'd0, fovf}, 64'd0);
    end
    prev_pls = pls;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      pls = 1'b1;
      stall_cnt--;
    end else begin
      pls = rand_pls ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (expq.size() != 0) begin
      check("drain_timeout", 64'(expq.size()), 64'd0);
      expq.delete();
    end
  endtask

  task automatic send_pkt(input int len, input logic [7:0] ch, input bit directed,
                          input int stall_at, input int abort_at);
    logic [63:0] w[$];
    exp_t        e;
    int          i = 0;
    int          cyc = 0;
    int          cnt;
    bit          hs;
    bit          tv = 1'b1;
    wait_idle();
    for (int k = 0; k < len; k++) w.push_back(directed ? 64'(k + 1) : {$urandom(), $urandom()});
    cnt = (len < MAXW) ? len : MAXW;
    e.d = {8'hAA, ch, exp_fid, ts_model}; e.ovf = 0; e.ftr = 0; expq.push_back(e);
    for (int k = 0; k < cnt; k++) begin
      e.d = w[k]; e.ovf = 0; e.ftr = 0; expq.push_back(e);
    end
    e.d = {8'h55, 7'd0, (len > MAXW), 16'(cnt), exp_fid, 16'h0000};
    e.ovf = (len > MAXW); e.ftr = 1;
    expq.push_back(e);
    exp_fid = exp_fid + 16'd1;
    ch_id = ch;
    while (i < len && cyc < 300) begin
      tvalid = tv; tdata = w[i]; tlast = (i == len - 1);
      @(negedge clk);
      if (stall_chk && pls) check("tready_stall", {63'd0, tready}, 64'd0);
      if (i >= MAXW) check("drop_tready", {63'd0, tready}, 64'd1);
      hs = tvalid && tready;
      if (hs && stall_at > 0 && i + 1 == stall_at) stall_cnt = 4;
      tick();
      if (hs) begin
        i++;
        tv = rand_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
        ch_id = 8'($urandom());
      end else begin
        tv = tvalid ? 1'b1 : ($urandom_range(0, 1) == 1);
      end
      cyc++;
      if (abort_at > 0 && i == abort_at) break;
    end
    tvalid = 1'b0; tlast = 1'b0;
    if (cyc >= 300) begin
      check("hs_timeout", 64'(i), 64'(len));
      expq.delete();
    end
    if (abort_at > 0 && i == abort_at) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expq.delete();
      exp_fid = 16'h0;
      @(negedge clk);
      check("abort_wr_en", {63'd0, wr_en}, 64'd0);
      check("abort_data", sdata, 64'd0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_data", sdata, 64'd0);
    check("rst_frame_ovf", {63'd0, fovf}, 64'd0);
    check("rst_tready", {63'd0, tready}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    send_pkt(3, 8'h05, 1, 0, 0);
    stall_chk = 1;
    send_pkt(3, 8'h05, 1, 2, 0);
    stall_chk = 0;
    send_pkt(7, 8'h11, 1, 0, 0);
    send_pkt(4, 8'h22, 1, 0, 0);

    wait_idle();
    force dut.frame_id_q = 16'hFFFF;
    tick();
    release dut.frame_id_q;
    exp_fid = 16'hFFFF;
    send_pkt(1, 8'h33, 0, 0, 0);
    send_pkt(1, 8'h44, 0, 0, 0);

    send_pkt(5, 8'h66, 0, 0, 2);
    send_pkt(2, 8'h77, 0, 0, 0);

    rand_pls = 1; rand_gap = 1;
    for (int p = 0; p < 40; p++) send_pkt($urandom_range(1, 9), 8'($urandom()), 0, 0, 0);
    rand_pls = 0; rand_gap = 0;
    wait_idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Upstream neighbour of the Ethernet TX interface.
- Takes a 64-bit AXI-Stream of hit words from the trigger/readout logic and wraps each TLAST-delimited packet in a header word and a footer word.
- Presents the result as a flat word stream (SERIALIZED_DATA + WR_EN) for the Ethernet interface FIFO.
- Honours that stage's PLS_WAIT back-pressure and enforces a maximum payload length per frame.

Parameters:
- S_AXIS_TDATA_WIDTH, 64, input stream width; only 64 supported.
- TX_RX_M_AXIS_WIDTH, 64, output word width; only 64 supported.
- MAX_WORDS, 256, maximum payload words per frame; range 1..65535.

Ports:
- TX_ACLK  input  1  single clock, all logic rising-edge.
- TX_ARESET  input  1  synchronous, active-high reset.
- S_AXIS_TDATA  input  64  payload word.
- S_AXIS_TVALID  input  1  payload word valid.
- S_AXIS_TLAST  input  1  last word of packet.
- S_AXIS_TREADY  output  1  payload word accepted when TVALID&TREADY.
- CH_ID  input  8  channel tag written into the header; sampled at frame start.
- PLS_WAIT  input  1  downstream stall; no word may be written while high.
- SERIALIZED_DATA  output  64  framed word to the Ethernet interface.
- WR_EN  output  1  one-cycle strobe; SERIALIZED_DATA valid this cycle.
- FRAME_OVF  output  1  one-cycle pulse with the footer of a truncated frame.

Behaviour:
- Reset (TX_ARESET=1 at a clock edge):
  - state=IDLE.
  - SERIALIZED_DATA=0, WR_EN=0, FRAME_OVF=0, S_AXIS_TREADY=0.
  - frame_id=0, word_cnt=0, ovf flag=0, timestamp=0.
  - Reset mid-frame abandons the frame silently: no footer is written.
- timestamp: free-running 32-bit counter, +1 per cycle, wraps 0xFFFFFFFF->0.
- All outputs are registered. An accepted payload word appears on SERIALIZED_DATA with WR_EN=1 exactly 1 cycle after its handshake. WR_EN is 0 on every cycle without a new word.
- Header word: {8'hAA, CH_ID, frame_id[15:0], ts_cap[31:0]}.
- Footer word: {8'h55, 7'b0, ovf, word_cnt[15:0], frame_id[15:0], 16'h0000}.
- FSM:
  - IDLE: TREADY=0. If TVALID=1: capture CH_ID and timestamp into ts_cap, clear word_cnt and ovf, go to HEADER.
  - HEADER: TREADY=0. If PLS_WAIT=0: write the header, go to PAYLOAD. Otherwise hold.
  - PAYLOAD: TREADY = !PLS_WAIT (combinational from state and PLS_WAIT). On each handshake: write the word, word_cnt+1.
    - If TLAST: go to FOOTER.
    - Else if word_cnt+1 == MAX_WORDS: set ovf, go to DROP.
  - DROP: TREADY=1 regardless of PLS_WAIT. Words are consumed and discarded, with no WR_EN and no word_cnt change. On TLAST handshake: go to FOOTER.
  - FOOTER: TREADY=0. If PLS_WAIT=0: write the footer, pulse FRAME_OVF=ovf, frame_id+1 (wraps 0xFFFF->0), go to IDLE.
- Boundaries:
  - A word accepted with TLAST exactly at MAX_WORDS is a normal frame, ovf=0.
  - TLAST on the first word gives a 1-word frame with footer word_cnt=1.
  - PLS_WAIT rising during PAYLOAD: the handshake in that cycle does not occur, and no data is lost.
  - Back-to-back frames: minimum one IDLE cycle between a footer and the next header.
  - TVALID dropping mid-frame: stay in PAYLOAD/DROP indefinitely. There is no timeout.
- Frame length on the output = word_cnt + 2 words.

Decomposition:
- Shared package frame_pkg holds:
  - HDR_MAGIC=8'hAA, FTR_MAGIC=8'h55.
  - State encoding constants IDLE/HEADER/PAYLOAD/DROP/FOOTER.
  - Header and footer field offsets, reused by the receive-side deframer and the bench.
- No sub-module. Single FSM, counters, and output register (~200 lines).

Test Plan:
- Reset, then a 3-word packet (1,2,3; TLAST on 3), CH_ID=8'h05, PLS_WAIT=0 -> WR_EN high for 5 words:
  - header with [63:56]=AA, [55:48]=05, frame_id=0;
  - 1, 2, 3;
  - footer with [63:56]=55, ovf=0, word_cnt=3, frame_id=0. FRAME_OVF stays 0.
- Same packet, PLS_WAIT=1 for 4 cycles after the 2nd payload word -> TREADY=0 and no WR_EN while stalled. Output sequence is identical to the previous case, with no dropped or duplicated word.
- MAX_WORDS=4, 7-word packet -> header, words 1..4, then footer with ovf=1 and word_cnt=4. FRAME_OVF pulses 1 cycle. Words 5..7 are consumed (TREADY=1) and never written.
- MAX_WORDS=4, 4-word packet with TLAST on word 4 -> footer ovf=0, word_cnt=4.
- Preload frame_id=0xFFFF, then two 1-word frames -> footers carry frame_id FFFF then 0000, word_cnt=1 each.
- Assert TX_ARESET after the 2nd payload word of a frame -> next cycle WR_EN=0 and no footer. The following packet produces a header with frame_id=0.
